// File: rtl/note_scan_mux_if.sv
// note_scan_mux_if: output stream of the note scanner.
//   x_out     : registered note word
//   chan_out  : channel index of x_out
//   valid_out : x_out/chan_out hold a valid transfer
//   ready_in  : downstream accepts when valid_out & ready_in
// master = scanner side, slave = downstream consumer.
interface note_scan_mux_if #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 32
);
  localparam int unsigned IDX_W = $clog2(CHANNELS);

  logic [WIDTH-1:0] x_out;
  logic [IDX_W-1:0] chan_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output x_out,
    output chan_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  x_out,
    input  chan_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/note_scan_mux.sv
// note_scan_mux: time-division note multiplexer. Scans CHANNELS note words of
// WIDTH bits, presenting each enabled channel once per pass on a valid/ready
// stream, in one-shot or loop mode.
//   clk_in   : clock, rising edge
//   rst_in   : synchronous active-high reset
//   x_in     : flattened notes, channel k at [k*WIDTH +: WIDTH]
//   mask_in  : per-channel enable (evaluated at load/handshake only)
//   start_in : begin a scan (honoured only when idle)
//   loop_in  : 1 = wrap to the first enabled channel after the last one
//   busy_out : scan in progress
//   done_out : one-cycle pulse when a scan ends
//   out_if   : x_out / chan_out / valid_out / ready_in stream
module note_scan_mux #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [CHANNELS*WIDTH-1:0]    x_in,
  input  logic [CHANNELS-1:0]          mask_in,
  input  logic                         start_in,
  input  logic                         loop_in,
  output logic                         busy_out,
  output logic                         done_out,
  note_scan_mux_if.master              out_if
);
  localparam int unsigned IDX_W = $clog2(CHANNELS);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [IDX_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] first_idx, next_idx;
  logic             has_first, has_next;
  logic             hs;
  logic             load_en;
  logic [IDX_W-1:0] load_idx;

  // Priority search over the live mask. Scanning from the top down lets the
  // lowest qualifying index overwrite any higher one. Indices only come from
  // set mask bits, so nothing >= CHANNELS can be produced.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_first = |mask_in;
    has_next  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (mask_in[CHANNELS-1-i]) begin
        first_idx = IDX_W'(CHANNELS-1-i);
        if (IDX_W'(CHANNELS-1-i) > chan_q) begin
          next_idx = IDX_W'(CHANNELS-1-i);
          has_next = 1'b1;
        end
      end
    end
  end

  assign hs = valid_q & out_if.ready_in;

  // State register (also holds the registered outputs)
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      x_q     <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_in && has_first) state_d = PRESENT;
      end
      PRESENT: begin
        if (hs && !has_next && !(loop_in && has_first)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: choose what to load and the next values of the registered outputs
  always_comb begin
    load_en  = 1'b0;
    load_idx = '0;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          if (has_first) begin
            load_en  = 1'b1;
            load_idx = first_idx;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (hs) begin
          if (has_next) begin
            load_en  = 1'b1;
            load_idx = next_idx;
          end else if (loop_in && has_first) begin
            load_en  = 1'b1;
            load_idx = first_idx;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    x_d    = load_en ? x_in[load_idx*WIDTH +: WIDTH] : x_q;
    chan_d = load_en ? load_idx : chan_q;
  end

  assign out_if.x_out     = x_q;
  assign out_if.chan_out  = chan_q;
  assign out_if.valid_out = valid_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
endmodule
